// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780 driver: command bytes, sequencer states
// and small helpers for picking init commands and line characters.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  typedef logic [2:0] state_t;
  localparam state_t ST_POWERUP = 3'd0;
  localparam state_t ST_INIT    = 3'd1;
  localparam state_t ST_ADDR1   = 3'd2;
  localparam state_t ST_LINE1   = 3'd3;
  localparam state_t ST_ADDR2   = 3'd4;
  localparam state_t ST_LINE2   = 3'd5;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = CMD_FUNC_SET;
      2'd1:    cmd = CMD_DISP_ON;
      2'd2:    cmd = CMD_CLEAR;
      2'd3:    cmd = CMD_ENTRY;
      default: cmd = CMD_FUNC_SET;
    endcase
    return cmd;
  endfunction

  // Column 0 sits in the top byte, so the byte base is 8 * (15 - col) = {~col, 000}.
  function automatic logic [7:0] line_char(input logic [127:0] line, input logic [3:0] col);
    logic [6:0] base;
    base = {~col, 3'b000};
    return line[base +: 8];
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Single-byte HD44780 write: latch RS/data, hold setup, pulse EN, then wait
// for the controller to execute; done marks the last wait cycle.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 5,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned WAIT_CYC  = 2_500,
  parameter int unsigned CLEAR_CYC = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] byte_i,
  input  logic       long_wait_i,
  output logic       done_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_SETUP = 2'd1;
  localparam logic [1:0] PH_EN    = 2'd2;
  localparam logic [1:0] PH_WAIT  = 2'd3;

  logic [1:0]  phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic        en_q, en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        long_q, long_d;
  logic [31:0] wait_lim_s;
  logic        done_s;

  assign wait_lim_s = long_q ? 32'(CLEAR_CYC) : 32'(WAIT_CYC);
  assign done_s     = (phase_q == PH_WAIT) && (cnt_q == wait_lim_s - 32'd1);

  // Phase sequencing and bus latching
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    long_d  = long_q;
    case (phase_q)
      PH_IDLE: begin
        if (start_i) begin
          rs_d    = rs_i;
          data_d  = byte_i;
          long_d  = long_wait_i;
          phase_d = PH_SETUP;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = 32'd0;
        end
      end
      PH_SETUP: begin
        if (cnt_q == 32'(SETUP_CYC) - 32'd1) begin
          phase_d = PH_EN;
          cnt_d   = 32'd0;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PH_EN: begin
        if (cnt_q == 32'(EN_CYC) - 32'd1) begin
          phase_d = PH_WAIT;
          cnt_d   = 32'd0;
          en_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      PH_WAIT: begin
        if (done_s) begin
          phase_d = PH_IDLE;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        phase_d = PH_IDLE;
        cnt_d   = 32'd0;
        en_d    = 1'b0;
      end
    endcase
  end

  // State registers; EN drops the moment reset asserts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_IDLE;
      cnt_q   <= 32'd0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      long_q  <= long_d;
    end
  end

  assign done_o     = done_s;
  assign lcd_en_o   = en_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_data_o = data_q;

endmodule

// File: rtl/lcd_hd44780_driver.sv
// HD44780 8-bit driver: one-time power-up/init, then endless refresh of two
// 16-character lines from a per-frame snapshot of L1/L2.
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = 1_000_000,
  parameter int unsigned SETUP_CYC   = 5,
  parameter int unsigned EN_CYC      = 25,
  parameter int unsigned WAIT_CYC    = 2_500,
  parameter int unsigned CLEAR_CYC   = 100_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] L1,
  input  logic [127:0] L2,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_en,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  state_t         state_q, state_d;
  logic [31:0]    pwr_cnt_q, pwr_cnt_d;
  logic [1:0]     init_idx_q, init_idx_d;
  logic [3:0]     col_q, col_d;
  logic [127:0]   snap1_q, snap1_d;
  logic [127:0]   snap2_q, snap2_d;
  logic           start_q, start_d;
  logic           init_done_q, init_done_d;

  logic           done_s;
  logic           rs_s;
  logic           long_s;
  logic [7:0]     byte_s;

  // Byte selection for the current sequencer step
  always_comb begin
    rs_s   = 1'b0;
    long_s = 1'b0;
    byte_s = 8'h00;
    case (state_q)
      ST_INIT: begin
        byte_s = init_cmd(init_idx_q);
        long_s = (init_idx_q == 2'd2);
      end
      ST_ADDR1: byte_s = CMD_LINE1;
      ST_LINE1: begin
        rs_s   = 1'b1;
        byte_s = line_char(snap1_q, col_q);
      end
      ST_ADDR2: byte_s = CMD_LINE2;
      ST_LINE2: begin
        rs_s   = 1'b1;
        byte_s = line_char(snap2_q, col_q);
      end
      default: byte_s = 8'h00;
    endcase
  end

  // Sequencer: start is a one-cycle pulse issued the cycle after each done
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = pwr_cnt_q;
    init_idx_d  = init_idx_q;
    col_d       = col_q;
    snap1_d     = snap1_q;
    snap2_d     = snap2_q;
    start_d     = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      ST_POWERUP: begin
        if (pwr_cnt_q == 32'(POWERUP_CYC) - 32'd1) begin
          state_d   = ST_INIT;
          pwr_cnt_d = 32'd0;
          start_d   = 1'b1;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 32'd1;
        end
      end
      ST_INIT: begin
        if (done_s) begin
          start_d = 1'b1;
          if (init_idx_q == 2'd3) begin
            state_d     = ST_ADDR1;
            init_idx_d  = 2'd0;
            init_done_d = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
          end
        end else begin
          init_idx_d = init_idx_q;
        end
      end
      ST_ADDR1: begin
        // Snapshot once per frame so mid-frame edits never tear the display
        if (start_q) begin
          snap1_d = L1;
          snap2_d = L2;
        end else begin
          snap1_d = snap1_q;
        end
        if (done_s) begin
          state_d = ST_LINE1;
          col_d   = 4'd0;
          start_d = 1'b1;
        end else begin
          col_d = col_q;
        end
      end
      ST_LINE1: begin
        if (done_s) begin
          col_d   = col_q + 4'd1;
          start_d = 1'b1;
          if (col_q == 4'd15) begin
            state_d = ST_ADDR2;
          end else begin
            state_d = ST_LINE1;
          end
        end else begin
          col_d = col_q;
        end
      end
      ST_ADDR2: begin
        if (done_s) begin
          state_d = ST_LINE2;
          start_d = 1'b1;
        end else begin
          state_d = ST_ADDR2;
        end
      end
      ST_LINE2: begin
        if (done_s) begin
          col_d   = col_q + 4'd1;
          start_d = 1'b1;
          if (col_q == 4'd15) begin
            state_d = ST_ADDR1;
          end else begin
            state_d = ST_LINE2;
          end
        end else begin
          col_d = col_q;
        end
      end
      default: state_d = ST_POWERUP;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_POWERUP;
      pwr_cnt_q   <= 32'd0;
      init_idx_q  <= 2'd0;
      col_q       <= 4'd0;
      snap1_q     <= 128'd0;
      snap2_q     <= 128'd0;
      start_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_cnt_q   <= pwr_cnt_d;
      init_idx_q  <= init_idx_d;
      col_q       <= col_d;
      snap1_q     <= snap1_d;
      snap2_q     <= snap2_d;
      start_q     <= start_d;
      init_done_q <= init_done_d;
    end
  end

  lcd_byte_writer #(
    .SETUP_CYC (SETUP_CYC),
    .EN_CYC    (EN_CYC),
    .WAIT_CYC  (WAIT_CYC),
    .CLEAR_CYC (CLEAR_CYC)
  ) u_writer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_q),
    .rs_i        (rs_s),
    .byte_i      (byte_s),
    .long_wait_i (long_s),
    .done_o      (done_s),
    .lcd_en_o    (lcd_en),
    .lcd_rs_o    (lcd_rs),
    .lcd_data_o  (lcd_data)
  );

  // Decoded from registers so the pulse lands exactly on the last character's done
  assign frame_done = done_s && (state_q == ST_LINE2) && (col_q == 4'd15);
  assign init_done  = init_done_q;
  assign lcd_rw     = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Scoreboard bench for lcd_hd44780_driver with short timing parameters.
module tb_lcd_hd44780_driver;

  localparam int unsigned P_POWERUP = 10;
  localparam int unsigned P_SETUP   = 2;
  localparam int unsigned P_EN      = 3;
  localparam int unsigned P_WAIT    = 4;
  localparam int unsigned P_CLEAR   = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] l1, l2;
  logic         lcd_rs, lcd_rw, lcd_en, init_done, frame_done;
  logic [7:0]   lcd_data;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fd_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc;

  lcd_hd44780_driver #(
    .POWERUP_CYC (P_POWERUP),
    .SETUP_CYC   (P_SETUP),
    .EN_CYC      (P_EN),
    .WAIT_CYC    (P_WAIT),
    .CLEAR_CYC   (P_CLEAR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .L1         (l1),
    .L2         (l2),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_en     (lcd_en),
    .lcd_data   (lcd_data),
    .init_done  (init_done),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges since rst_n was released
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] data, input int c);
    exp_t e;
    e.rs = rs;
    e.data = data;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_byte(1'b0, 8'h38, 13);
    push_byte(1'b0, 8'h0C, 23);
    push_byte(1'b0, 8'h01, 33);
    push_byte(1'b0, 8'h06, 47);
  endtask

  // A frame whose ADDR1 start is cycle s: 34 bytes every 10 cycles, EN rises 3 after start
  task automatic push_frame(input logic [127:0] a, input logic [127:0] b, input int s);
    push_byte(1'b0, 8'h80, s + 3);
    for (int j = 0; j < 16; j++)
      push_byte(1'b1, a[127 - 8*j -: 8], s + 13 + 10*j);
    push_byte(1'b0, 8'hC0, s + 173);
    for (int j = 0; j < 16; j++)
      push_byte(1'b1, b[127 - 8*j -: 8], s + 183 + 10*j);
    fd_q.push_back(s + 339);
  endtask

  // Monitor: compares every EN rise, EN width, bus stability, rw, init_done, frame_done
  initial begin
    logic       prev_en;
    int         hi_cnt;
    logic [8:0] held;
    exp_t       e;
    int         fc;
    prev_en = 1'b0;
    hi_cnt = 0;
    held = 9'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0;
        hi_cnt = 0;
      end else begin
        check("rw_zero", {31'd0, lcd_rw}, 32'd0);
        check("init_done", {31'd0, init_done}, {31'd0, cyc >= 54});
        if (lcd_en && !prev_en) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte at cycle %0d: got %0h with no byte expected", cyc, lcd_data);
          end else begin
            e = exp_q.pop_front();
            check("byte_data", {24'd0, lcd_data}, {24'd0, e.data});
            check("byte_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
            check("rise_cycle", cyc, e.cyc);
          end
          held = {lcd_rs, lcd_data};
          hi_cnt = 1;
        end else if (lcd_en) begin
          check("bus_stable_en_high", {23'd0, lcd_rs, lcd_data}, {23'd0, held});
          hi_cnt++;
        end else if (prev_en) begin
          check("en_width", hi_cnt, 32'd3);
        end
        if (frame_done) begin
          if (fd_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_frame_done at cycle %0d: got pulse, expected none", cyc);
          end else begin
            fc = fd_q.pop_front();
            check("frame_done_cycle", cyc, fc);
          end
        end
        prev_en = lcd_en;
      end
    end
  end

  // Stimulus
  initial begin
    l1 = "HELLO WORLD     ";
    l2 = "0123456789ABCDEF";
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {18'd0, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done}, 32'd0);

    @(negedge clk);
    push_init();
    push_frame(l1, l2, 54);
    rst_n = 1'b1;

    while (cyc < 100) @(posedge clk);
    #1;
    l1 = "GOODBYE WORLD!  ";
    push_frame(l1, l2, 394);

    while (cyc < 500) @(posedge clk);
    #1;
    l2 = 128'h00FF807FC0A55A010203040506070809;
    push_frame(l1, l2, 734);
    push_frame(l1, l2, 1074);

    while (cyc < 1100) @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (lcd_en) break;
    end
    check("en_high_before_reset", {31'd0, lcd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("en_async_drop", {31'd0, lcd_en}, 32'd0);
    check("reset_outputs_mid", {18'd0, lcd_rs, lcd_rw, lcd_en, lcd_data, init_done, frame_done}, 32'd0);
    exp_q.delete();
    fd_q.delete();

    repeat (3) @(posedge clk);
    @(negedge clk);
    push_init();
    push_frame(l1, l2, 54);
    rst_n = 1'b1;

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && fd_q.size() == 0) break;
    end
    check("queues_drained", exp_q.size() + fd_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_driver.md
# lcd_hd44780_driver

Downstream consumer of the LCD line registers: it takes the two 128-bit display lines (L1, L2, 16 ASCII characters each) and drives an HD44780-compatible character LCD in 8-bit mode. The block runs the power-up initialisation once. It then refreshes both lines continuously, sending one byte at a time with programmable setup, enable-pulse and execution-wait times. It is the last stage before the board's LCD pins.

## Interface
Parameters (all in clock cycles; defaults are for a 50 MHz clk):
- POWERUP_CYC, 1_000_000: wait after reset before the first command (20 ms)
- SETUP_CYC, 5: cycles that RS/data are stable before EN rises
- EN_CYC, 25: EN high width (500 ns)
- WAIT_CYC, 2_500: EN-low execution wait after a normal byte (50 µs)
- CLEAR_CYC, 100_000: EN-low execution wait after the clear command (2 ms)

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- L1  in  128  line 1 text; bits [127:120] are column 0, bits [7:0] are column 15
- L2  in  128  line 2 text; same byte order as L1
- lcd_rs  out  1  0 = command, 1 = character data
- lcd_rw  out  1  constant 0 (write only)
- lcd_en  out  1  LCD enable strobe
- lcd_data  out  8  LCD data bus
- init_done  out  1  high after the fourth init command completes; stays high until reset
- frame_done  out  1  one-cycle pulse when the last L2 character completes

## Operation
- State sequence: POWERUP → INIT → ADDR1 → LINE1 → ADDR2 → LINE2, then back to ADDR1 forever.
- POWERUP: count POWERUP_CYC cycles with all outputs at their reset values.
- INIT: send four commands in order, tracked by an index 0..3:
  - 0x38: 8-bit bus, 2 lines, 5x8 font
  - 0x0C: display on, cursor off
  - 0x01: clear; followed by a CLEAR_CYC wait instead of WAIT_CYC
  - 0x06: increment address, no shift
- ADDR1: snapshot L1 and L2 into internal frame registers, then send command 0x80. Because of the snapshot, input changes during a frame do not show until the next frame (no tearing).
- LINE1: send 16 data bytes (RS = 1) from snapshot columns 0..15, using a 4-bit column counter that wraps to 0.
- ADDR2: send command 0xC0.
- LINE2: send 16 data bytes from the L2 snapshot; frame_done pulses when the 16th byte completes.
- Byte transaction, as a start/done handshake with the byte writer:
  - Cycle 0 (start): lcd_rs and lcd_data take the new value.
  - Next SETUP_CYC cycles: EN low.
  - Next EN_CYC cycles: EN high.
  - Next WAIT_CYC (or CLEAR_CYC) cycles: EN low; done is asserted in the last of these cycles.
  - The next start follows in the cycle after done.
  - lcd_rs and lcd_data hold stable from start until the next start.
- Reset values: lcd_rs = 0, lcd_rw = 0, lcd_en = 0, lcd_data = 0x00, init_done = 0, frame_done = 0, state = POWERUP, all counters = 0.
- Reset mid-operation (including while EN is high): EN drops immediately, asynchronously; the full POWERUP and INIT sequence repeats.
- Any byte value is passed through unchanged, including 0x00 and values ≥ 0x80.

## Timing
- Spacing between consecutive EN rising edges: SETUP_CYC + EN_CYC + WAIT_CYC + 1 cycles. Use CLEAR_CYC in place of WAIT_CYC after 0x01.
- First EN rise: POWERUP_CYC + SETUP_CYC + 1 cycles after rst_n deasserts.
- Each frame is 34 byte transactions (2 addresses + 32 characters). INIT happens only once after reset.
- init_done rises in the cycle after the done of command 0x06.
- frame_done is high for exactly one cycle, coincident with the done of the last character.

## Structure
- Shared package lcd_pkg holds:
  - command constants: CMD_FUNC_SET = 0x38, CMD_DISP_ON = 0x0C, CMD_CLEAR = 0x01, CMD_ENTRY = 0x06, CMD_LINE1 = 0x80, CMD_LINE2 = 0xC0
  - the state enumeration
- One sub-module, lcd_byte_writer:
  - inputs: start, rs, byte, long_wait
  - outputs: done, lcd_en, lcd_rs, lcd_data
  - owns the phase counter
- The top level owns the sequencing state machine, the init index, the column counter and the snapshot registers.

## Test plan
Simulation parameters: POWERUP_CYC = 10, SETUP_CYC = 2, EN_CYC = 3, WAIT_CYC = 4, CLEAR_CYC = 8.
- Reset release → first EN rise at cycle 13, lcd_data = 0x38, rs = 0; EN high for exactly 3 cycles.
- Init sequence → bytes 0x38, 0x0C, 0x01, 0x06 appear in order; rising-edge spacing is 10, 10, 14 cycles; init_done rises after 0x06.
- L1 = "HELLO WORLD     ", L2 = "0123456789ABCDEF" → bus shows 0x80, 'H' … ' ', 0xC0, '0' … 'F' with rs correct on every byte; frame_done pulses once per 340 cycles.
- Change L1 mid-LINE1 → the current frame still shows the old text; the next frame shows the new text.
- rst_n low while EN is high → EN = 0 in the same cycle; after release, the first EN rise again lands at cycle 13 with 0x38.
- lcd_rs and lcd_data never change while EN is high, and lcd_rw = 0 throughout (assertion-checked over 3 frames).
